dp2_calculator: RTL and testbench

- Small multi-cycle 3-bit calculator: FSM controller plus register datapath.
- On Go, latches two operands and an opcode, then executes one ALU operation (add, sub, and, xor).
- Presents the result on out with a one-cycle Done pulse.
- Exposes its current state on CSout for debug and visibility.

---
 rtl/dp2_calculator.sv | 104 ++++++++++
 tb/tb_dp2_calculator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dp2_calculator.sv
// Multi-cycle W-bit calculator: FSM controller with operand, opcode and result registers.
// Define DP2_SAT_EN to make ADD/SUB saturate instead of wrapping modulo 2^W.
module dp2_calculator #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Go,
    input  logic [1:0]   Op,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic [W-1:0] out,
    output logic [3:0]   CSout,
    output logic         Done
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_DECODE = 4'd2,
        S_ADD    = 4'd3,
        S_SUB    = 4'd4,
        S_AND    = 4'd5,
        S_XOR    = 4'd6,
        S_DONE   = 4'd7
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_reg, b_reg, result;
    logic [1:0]     op_reg;

    function automatic logic [W-1:0] add_op(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
`ifdef DP2_SAT_EN
        return s[W] ? {W{1'b1}} : s[W-1:0];
`else
        return s[W-1:0];
`endif
    endfunction

    function automatic logic [W-1:0] sub_op(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef DP2_SAT_EN
        return (x < y) ? {W{1'b0}} : (x - y);
`else
        return x - y;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = Go ? S_LOAD : S_IDLE;
            S_LOAD:   state_nxt = S_DECODE;
            S_DECODE: begin
                case (op_reg)
                    2'b00:   state_nxt = S_ADD;
                    2'b01:   state_nxt = S_SUB;
                    2'b10:   state_nxt = S_AND;
                    default: state_nxt = S_XOR;
                endcase
            end
            S_ADD, S_SUB, S_AND, S_XOR: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Operands are captured only in LOAD, so later input changes cannot disturb a running op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            result <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    a_reg  <= in1;
                    b_reg  <= in2;
                    op_reg <= Op;
                end
                S_ADD:   result <= add_op(a_reg, b_reg);
                S_SUB:   result <= sub_op(a_reg, b_reg);
                S_AND:   result <= a_reg & b_reg;
                S_XOR:   result <= a_reg ^ b_reg;
                default: ;
            endcase
        end
    end

    assign out   = result;
    assign CSout = state;
    assign Done  = (state == S_DONE);

endmodule

// File: tb/tb_dp2_calculator.sv
// Directed bench for dp2_calculator: scoreboard queue of expected results, immediate-assertion checks.
module tb_dp2_calculator;

    logic       clk;
    logic       rst_n;
    logic       Go;
    logic [1:0] Op;
    logic [2:0] in1, in2;
    logic [2:0] out;
    logic [3:0] CSout;
    logic       Done;

    int vectors = 0;
    int errors  = 0;
    logic [2:0] exp_q[$];

    dp2_calculator #(.W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Go    (Go),
        .Op    (Op),
        .in1   (in1),
        .in2   (in2),
        .out   (out),
        .CSout (CSout),
        .Done  (Done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete operation, sampled on falling edges; optionally perturbs inputs once LOAD has passed
    task automatic run_op(input string name, input logic [2:0] a, input logic [2:0] b,
                          input logic [1:0] op, input logic [3:0] opst,
                          input logic [2:0] expv, input bit chg);
        logic [2:0] e;
        e = 3'd0;
        @(negedge clk);
        in1 = a; in2 = b; Op = op; Go = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        Go = 1'b0;
        check({name, "_load"}, 32'(CSout), 32'd1);
        @(negedge clk);
        check({name, "_decode"}, 32'(CSout), 32'd2);
        if (chg) begin
            in1 = 3'd0;
            Op  = 2'b11;
        end
        @(negedge clk);
        check({name, "_opstate"}, 32'(CSout), 32'(opst));
        check({name, "_done_low"}, 32'(Done), 32'd0);
        @(negedge clk);
        check({name, "_done_state"}, 32'(CSout), 32'd7);
        check({name, "_done"}, 32'(Done), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, "_out"}, 32'(out), 32'(e));
        end else begin
            check({name, "_scoreboard"}, 32'(exp_q.size()), 32'd1);
        end
        @(negedge clk);
        check({name, "_idle"}, 32'(CSout), 32'd0);
        check({name, "_done_clr"}, 32'(Done), 32'd0);
        check({name, "_out_hold"}, 32'(out), 32'(e));
    endtask

    initial begin
        int cyc;
        int ndone;
        int pos[3];
        bit seen;

        rst_n = 1'b0; Go = 1'b1; Op = 2'b00; in1 = 3'd0; in2 = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs", 32'(CSout), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        Go = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_release_idle", 32'(CSout), 32'd0);

        run_op("xor", 3'd5, 3'd2, 2'b11, 4'd6, 3'd7, 1'b0);
`ifdef DP2_SAT_EN
        run_op("add", 3'd5, 3'd4, 2'b00, 4'd3, 3'd7, 1'b0);
        run_op("sub", 3'd2, 3'd5, 2'b01, 4'd4, 3'd0, 1'b0);
`else
        run_op("add", 3'd5, 3'd4, 2'b00, 4'd3, 3'd1, 1'b0);
        run_op("sub", 3'd2, 3'd5, 2'b01, 4'd4, 3'd5, 1'b0);
`endif
        run_op("and", 3'd6, 3'd3, 2'b10, 4'd5, 3'd2, 1'b1);
        run_op("sub_plain", 3'd6, 3'd2, 2'b01, 4'd4, 3'd4, 1'b0);

        // Go held high: back-to-back operations every 5 clocks
        @(negedge clk);
        in1 = 3'd1; in2 = 3'd1; Op = 2'b00; Go = 1'b1;
        ndone = 0;
        cyc = 0;
        pos[0] = 0; pos[1] = 0; pos[2] = 0;
        while (ndone < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (Done) begin
                check("goheld_out", 32'(out), 32'd2);
                pos[ndone] = cyc;
                ndone++;
                if (ndone == 3) Go = 1'b0;
            end
        end
        Go = 1'b0;
        check("goheld_pulses", 32'(ndone), 32'd3);
        check("goheld_first", 32'(pos[0]), 32'd4);
        check("goheld_gap1", 32'(pos[1] - pos[0]), 32'd5);
        check("goheld_gap2", 32'(pos[2] - pos[1]), 32'd5);
        @(negedge clk);
        check("goheld_stop_idle", 32'(CSout), 32'd0);

        // Reset in the middle of an ADD aborts it
        in1 = 3'd5; in2 = 3'd4; Op = 2'b00; Go = 1'b1;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (CSout == 4'd3) seen = 1'b1;
        end
        check("midrst_reach_add", 32'(seen), 32'd1);
        Go = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cs", 32'(CSout), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (Done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        check("midrst_idle", 32'(CSout), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
